fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch front end: program counter, instruction register and a single shared memory port. Generalises the fixed 8-bit-address / 16-bit-data PC+IR datapath with a handshaked memory interface, branch redirect, stall, and an arbitrated data-access path that shares the memory port. Sits between the unified instruction/data RAM and the decode/execute controller.

## Interface
- ADDR_WIDTH, 8, PC / memory address width
- DATA_WIDTH, 16, instruction and data word width
- RESET_PC, 0, PC value after reset (ADDR_WIDTH bits)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; one clock, no other clock domains
- start  in  1  leave IDLE and begin fetching
- stall  in  1  hold IR; ir_ack ignored while high
- redirect  in  1  load PC from redirect_addr (branch/jump)
- redirect_addr  in  ADDR_WIDTH  redirect target
- ir  out  DATA_WIDTH  instruction register
- ir_valid  out  1  ir holds a live instruction
- ir_ack  in  1  consumer done with ir
- pc  out  ADDR_WIDTH  address of next fetch
- data_req  in  1  execute-stage memory access request
- data_addr  in  ADDR_WIDTH  data access address
- data_we  in  1  1 = store, 0 = load
- data_wdata  in  DATA_WIDTH  store data
- data_rdata  out  DATA_WIDTH  load result, valid when data_done
- data_done  out  1  one-cycle completion pulse
- mem_req, mem_we  out  1  memory request / write enable (registered)
- mem_addr  out  ADDR_WIDTH  memory address (registered, stable while mem_req)
- mem_wdata  out  DATA_WIDTH  memory write data (registered)
- mem_rdata  in  DATA_WIDTH  memory read data
- mem_valid  in  1  memory completes current request this cycle

## Operation
- Reset values: pc=RESET_PC, ir=0, ir_valid=0, data_rdata=0, data_done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, state IDLE.
- States: IDLE, FETCH, FULL, DATA.
- IDLE: priority redirect > data_req > start. redirect loads pc, stays IDLE. data_req -> DATA (return IDLE). start -> FETCH.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc latched on entry. On mem_valid: ir<=mem_rdata, ir_valid<=1, pc<=pc+1 (mod 2^ADDR_WIDTH, wraps to 0), -> FULL. redirect in FETCH: pc<=redirect_addr, kill flag set; the pending response is discarded (ir, pc unchanged by it), then FETCH reissues at new pc. stall has no effect.
- FULL: ir held. Priority redirect > data_req > (ir_ack && !stall). redirect: pc<=redirect_addr, ir_valid<=0, -> FETCH. data_req: latch data_addr/we/wdata, -> DATA, ir/ir_valid held (return FULL). ir_ack && !stall: ir_valid<=0, -> FETCH.
- DATA: mem_req=1, mem_addr/mem_we/mem_wdata from latched request. On mem_valid: data_done=1 for one cycle, data_rdata<=mem_rdata on loads (unchanged on stores), return to origin state. redirect in DATA: pc loaded, no state change; if origin FULL, ir_valid<=0 and return to FETCH instead.
- mem_valid ignored in IDLE and FULL. data_req must be held until data_done; sampled only in IDLE/FULL.
- ir never changes while ir_valid=1 except by redirect clearing ir_valid.

## Timing
- mem_* outputs registered: asserted the cycle after state entry, deasserted the cycle after mem_valid.
- Zero-wait memory (mem_valid in first req cycle): start at cycle 0 -> mem_req cycle 1 -> ir_valid cycle 2.
- Sustained throughput with zero-wait memory and ir_ack held high: one instruction per 2 cycles.
- Data access latency: data_req sampled cycle n -> mem_req n+1 -> data_done the cycle after mem_valid.
- Reset asserted mid-request: all state cleared immediately; any later mem_valid ignored (IDLE).

## Structure
- Package fetch_pkg: fetch_state_t enum (IDLE, FETCH, FULL, DATA), default width localparams.
- Sub-module fetch_pc: PC register with async reset to RESET_PC, redirect load, increment enable, wrap-around.
- Remainder (FSM, IR, memory request registers) in fetch_unit.

## Test plan
- Reset, start, zero-wait memory returning 0x1234 at addr 0 -> ir=0x1234, ir_valid=1 cycle 2, pc=1.
- RESET_PC=8'hFF, one fetch -> pc wraps to 0x00.
- FULL with ir_ack=1, stall=1 for 3 cycles -> ir unchanged, no mem_req; stall drop -> FETCH next cycle.
- redirect to 0x40 while FETCH waiting (mem_valid delayed 3 cycles) -> response discarded, next mem_addr=0x40.
- In FULL, load from 0x80 (mem returns 0xBEEF) -> data_done pulse, data_rdata=0xBEEF, ir/ir_valid unchanged, return FULL; store writes mem_we=1, mem_wdata correct.
- reset asserted mid-DATA -> all outputs to reset values same cycle; late mem_valid causes no change.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction-fetch front end.
// Holds the fetch/data FSM state encoding used by fetch_unit.
package fetch_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 8;
    localparam int unsigned DEF_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2,
        DATA  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc.sv
// Program counter: async reset to RESET_PC, redirect load beats increment, wraps at 2^ADDR_WIDTH.
// Updates one cycle after load/inc; pc_nxt exposes the value the register takes at the next edge.
module fetch_pc
    import fetch_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pc_nxt
);

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = 1;

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_addr;
        end else if (inc) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc     = pc_q;
    assign pc_nxt = pc_d;

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC + IR with one shared, registered memory port also used for data loads/stores.
// Fetch/data latency is one cycle after mem_valid; IR is held (no new fetch) until ir_ack with stall low.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned            DATA_WIDTH = DEF_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic [DATA_WIDTH-1:0] ir,
    output logic                  ir_valid,
    input  logic                  ir_ack,
    output logic [ADDR_WIDTH-1:0] pc,
    input  logic                  data_req,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic                  data_we,
    input  logic [DATA_WIDTH-1:0] data_wdata,
    output logic [DATA_WIDTH-1:0] data_rdata,
    output logic                  data_done,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_valid
);

    fetch_state_t state_q, state_d;
    fetch_state_t ret_q, ret_d;
    logic         kill_q, kill_d;

    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic                  ir_valid_q, ir_valid_d;
    logic [DATA_WIDTH-1:0] data_rdata_q, data_rdata_d;
    logic                  data_done_q, data_done_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

    logic                  fetch_hit;
    logic [ADDR_WIDTH-1:0] pc_nxt;

    // A response only lands in IR if no redirect is pending or arriving with it.
    assign fetch_hit = (state_q == FETCH) && mem_valid && !kill_q && !redirect;

    fetch_pc #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .reset     (reset),
        .load      (redirect),
        .load_addr (redirect_addr),
        .inc       (fetch_hit),
        .pc        (pc),
        .pc_nxt    (pc_nxt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ret_q   <= IDLE;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            kill_q  <= kill_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        kill_d  = kill_q;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    state_d = IDLE;
                end else if (data_req) begin
                    state_d = DATA;
                    ret_d   = IDLE;
                end else if (start) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (mem_valid) begin
                    kill_d = 1'b0;
                    if (!kill_q && !redirect) begin
                        state_d = FULL;
                    end
                end else if (redirect) begin
                    kill_d = 1'b1;
                end
            end
            FULL: begin
                if (redirect) begin
                    state_d = FETCH;
                end else if (data_req) begin
                    state_d = DATA;
                    ret_d   = FULL;
                end else if (ir_ack && !stall) begin
                    state_d = FETCH;
                end
            end
            DATA: begin
                // A redirect while parked from FULL makes the held instruction stale.
                if (redirect && ret_q == FULL) begin
                    ret_d = FETCH;
                end
                if (mem_valid) begin
                    state_d = ret_d;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ir_d         = ir_q;
        ir_valid_d   = ir_valid_q;
        data_rdata_d = data_rdata_q;
        data_done_d  = 1'b0;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        if (fetch_hit) begin
            ir_d       = mem_rdata;
            ir_valid_d = 1'b1;
        end
        if ((state_q == FULL && state_d == FETCH) ||
            (state_q == DATA && redirect && ret_q == FULL)) begin
            ir_valid_d = 1'b0;
        end
        if (state_q == DATA && mem_valid) begin
            data_done_d = 1'b1;
            if (!mem_we_q) begin
                data_rdata_d = mem_rdata;
            end
        end

        // Memory port registers are loaded from the state being entered.
        mem_req_d = (state_d == FETCH) || (state_d == DATA);
        if (state_d == DATA && state_q != DATA) begin
            mem_addr_d  = data_addr;
            mem_we_d    = data_we;
            mem_wdata_d = data_wdata;
        end else if (state_d == FETCH && (state_q != FETCH || mem_valid)) begin
            mem_addr_d = pc_nxt;
            mem_we_d   = 1'b0;
        end else if (state_d != DATA) begin
            mem_we_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q         <= '0;
            ir_valid_q   <= 1'b0;
            data_rdata_q <= '0;
            data_done_q  <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            ir_q         <= ir_d;
            ir_valid_q   <= ir_valid_d;
            data_rdata_q <= data_rdata_d;
            data_done_q  <= data_done_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign ir         = ir_q;
    assign ir_valid   = ir_valid_q;
    assign data_rdata = data_rdata_q;
    assign data_done  = data_done_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-programmable memory responder, transaction-level reference model
// checked every cycle, and directed scenarios with hand-computed expectations.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, stall = 1'b0, redirect = 1'b0, ir_ack = 1'b0;
    logic [7:0]  redirect_addr = '0;
    logic        data_req = 1'b0, data_we = 1'b0;
    logic [7:0]  data_addr = '0;
    logic [15:0] data_wdata = '0;
    logic [15:0] ir, data_rdata, mem_wdata;
    logic        ir_valid, data_done, mem_req, mem_we;
    logic [7:0]  pc, mem_addr;
    logic [15:0] mem_rdata = '0;
    logic        mem_valid = 1'b0;

    logic [15:0] ir2, data_rdata2, mem_wdata2;
    logic        ir_valid2, data_done2, mem_req2, mem_we2;
    logic [7:0]  pc2, mem_addr2;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;
    int lat = 0;
    int wait_cnt = 0;
    bit force_valid = 1'b0;
    int vcount;
    logic [15:0] mem_arr [256];

    always #5 clk = ~clk;

    fetch_unit u_dut (
        .clk(clk), .reset(reset), .start(start), .stall(stall), .redirect(redirect),
        .redirect_addr(redirect_addr), .ir(ir), .ir_valid(ir_valid), .ir_ack(ir_ack), .pc(pc),
        .data_req(data_req), .data_addr(data_addr), .data_we(data_we), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .data_done(data_done), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_valid(mem_valid)
    );

    fetch_unit #(.RESET_PC(8'hFF)) u_dut2 (
        .clk(clk), .reset(reset), .start(start), .stall(1'b0), .redirect(1'b0),
        .redirect_addr(8'h00), .ir(ir2), .ir_valid(ir_valid2), .ir_ack(1'b0), .pc(pc2),
        .data_req(1'b0), .data_addr(8'h00), .data_we(1'b0), .data_wdata(16'h0000),
        .data_rdata(data_rdata2), .data_done(data_done2), .mem_req(mem_req2), .mem_we(mem_we2),
        .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_rdata(16'hA5A5), .mem_valid(mem_req2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory: answers 'lat' cycles into each request; a completed request followed by mem_req still high is a new one.
    always @(posedge clk) begin
        #1;
        if (mem_req) begin
            if (mem_valid) wait_cnt = 0;
            mem_valid = (wait_cnt >= lat);
            wait_cnt = wait_cnt + 1;
        end else begin
            wait_cnt = 0;
            mem_valid = 1'b0;
        end
        if (force_valid) mem_valid = 1'b1;
        mem_rdata = mem_arr[mem_addr];
        if (mem_valid && mem_req && mem_we) mem_arr[mem_addr] = mem_wdata;
    end

    // Reference model: what is outstanding on the port, what the consumer holds, where a data access returns to.
    logic [7:0]  m_pc, m_faddr, m_daddr;
    logic [15:0] m_ir, m_drd, m_dwd;
    bit m_irv, m_done, m_fetching, m_data, m_dwe, m_kill, m_ret_full, m_ret_fetch;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc = 8'h00; m_faddr = '0; m_daddr = '0; m_ir = '0; m_drd = '0; m_dwd = '0;
            m_irv = 0; m_done = 0; m_fetching = 0; m_data = 0; m_dwe = 0;
            m_kill = 0; m_ret_full = 0; m_ret_fetch = 0;
        end else begin
            m_done = 0;
            if (m_fetching) begin
                if (mem_valid && !m_kill && !redirect) begin
                    m_ir = mem_rdata; m_irv = 1; m_pc = m_pc + 8'd1; m_fetching = 0;
                end else begin
                    if (redirect) m_pc = redirect_addr;
                    if (mem_valid) begin
                        m_kill = 0; m_faddr = m_pc;
                    end else if (redirect) begin
                        m_kill = 1;
                    end
                end
            end else if (m_data) begin
                if (redirect) begin
                    m_pc = redirect_addr;
                    if (m_ret_full) begin m_ret_full = 0; m_ret_fetch = 1; m_irv = 0; end
                end
                if (mem_valid) begin
                    m_done = 1;
                    if (!m_dwe) m_drd = mem_rdata;
                    m_data = 0; m_dwe = 0; m_ret_full = 0;
                    if (m_ret_fetch) begin m_fetching = 1; m_faddr = m_pc; m_ret_fetch = 0; end
                end
            end else if (redirect) begin
                m_pc = redirect_addr;
                if (m_irv) begin m_irv = 0; m_fetching = 1; m_faddr = m_pc; end
            end else if (data_req) begin
                m_data = 1; m_daddr = data_addr; m_dwe = data_we; m_dwd = data_wdata; m_ret_full = m_irv;
            end else if (m_irv ? (ir_ack && !stall) : start) begin
                m_irv = 0; m_fetching = 1; m_faddr = m_pc;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("pc", 32'(pc), 32'(m_pc));
            chk("ir", 32'(ir), 32'(m_ir));
            chk("ir_valid", 32'(ir_valid), 32'(m_irv));
            chk("data_done", 32'(data_done), 32'(m_done));
            chk("data_rdata", 32'(data_rdata), 32'(m_drd));
            chk("mem_req", 32'(mem_req), 32'(m_fetching || m_data));
            chk("mem_we", 32'(mem_we), 32'(m_data && m_dwe));
            if (m_fetching || m_data) chk("mem_addr", 32'(mem_addr), 32'(m_data ? m_daddr : m_faddr));
            if (m_data && m_dwe) chk("mem_wdata", 32'(mem_wdata), 32'(m_dwd));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 200000", $time);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = 16'h5A00 | 16'(i);
        mem_arr[8'h00] = 16'h1234;
        mem_arr[8'h40] = 16'hC0DE;
        mem_arr[8'h80] = 16'hBEEF;
        mem_arr[8'h10] = 16'h7777;

        repeat (3) @(posedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rst_pc", 32'(pc), 32'h00);
        chk("rst_ir", 32'(ir), 32'h0000);
        chk("rst_ir_valid", 32'(ir_valid), 32'h0);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h00);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'h0000);
        chk("rst_data_rdata", 32'(data_rdata), 32'h0000);
        chk("rst_pc_resetpc_ff", 32'(pc2), 32'hFF);

        // Zero-wait first fetch: start in cycle 0, request in cycle 1, instruction in cycle 2.
        step(); reset = 1'b0; start = 1'b1;
        step(); start = 1'b0;
        @(negedge clk);
        chk("c1_mem_req", 32'(mem_req), 32'h1);
        chk("c1_mem_addr", 32'(mem_addr), 32'h00);
        chk("c1_dut2_mem_addr", 32'(mem_addr2), 32'hFF);
        step();
        @(negedge clk);
        chk("c2_ir", 32'(ir), 32'h1234);
        chk("c2_ir_valid", 32'(ir_valid), 32'h1);
        chk("c2_pc", 32'(pc), 32'h01);
        chk("wrap_pc", 32'(pc2), 32'h00);
        chk("wrap_ir", 32'(ir2), 32'hA5A5);
        chk("wrap_ir_valid", 32'(ir_valid2), 32'h1);
        chk("dut2_no_data", {data_rdata2, mem_wdata2}, 32'h0);
        chk("dut2_no_done", 32'({data_done2, mem_we2}), 32'h0);

        // Stall holds the instruction despite ir_ack.
        ir_ack = 1'b1; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk("stall_ir", 32'(ir), 32'h1234);
            chk("stall_ir_valid", 32'(ir_valid), 32'h1);
            chk("stall_mem_req", 32'(mem_req), 32'h0);
        end
        stall = 1'b0;
        step(); ir_ack = 1'b0;
        @(negedge clk);
        chk("unstall_mem_req", 32'(mem_req), 32'h1);
        chk("unstall_mem_addr", 32'(mem_addr), 32'h01);
        chk("unstall_ir_valid", 32'(ir_valid), 32'h0);
        step();
        @(negedge clk);
        chk("fetch2_ir", 32'(ir), 32'h5A01);
        chk("fetch2_pc", 32'(pc), 32'h02);

        // Back-to-back fetches with ir_ack held: one instruction every two cycles.
        ir_ack = 1'b1;
        vcount = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            @(negedge clk);
            if (ir_valid) vcount++;
        end
        ir_ack = 1'b0;
        chk("thru_valid_cycles", 32'(vcount), 32'd4);
        chk("thru_pc", 32'(pc), 32'h06);
        chk("thru_ir", 32'(ir), 32'h5A05);

        // Redirect while a slow fetch is outstanding: its response must be dropped.
        lat = 3; ir_ack = 1'b1;
        step(); ir_ack = 1'b0; redirect = 1'b1; redirect_addr = 8'h40;
        @(negedge clk);
        chk("kill_first_addr", 32'(mem_addr), 32'h06);
        step(); redirect = 1'b0;
        @(negedge clk);
        chk("kill_pc", 32'(pc), 32'h40);
        chk("kill_addr_stable", 32'(mem_addr), 32'h06);
        step(); step(); step();
        @(negedge clk);
        chk("kill_reissue_addr", 32'(mem_addr), 32'h40);
        chk("kill_reissue_req", 32'(mem_req), 32'h1);
        chk("kill_ir_kept", 32'(ir), 32'h5A05);
        chk("kill_ir_valid", 32'(ir_valid), 32'h0);
        lat = 0;
        step(); step();
        @(negedge clk);
        chk("redir_ir", 32'(ir), 32'hC0DE);
        chk("redir_pc", 32'(pc), 32'h41);

        // Load from FULL, then store.
        data_req = 1'b1; data_addr = 8'h80; data_we = 1'b0;
        step();
        @(negedge clk);
        chk("ld_mem_addr", 32'(mem_addr), 32'h80);
        chk("ld_mem_we", 32'(mem_we), 32'h0);
        step();
        @(negedge clk);
        data_req = 1'b0;
        chk("ld_done", 32'(data_done), 32'h1);
        chk("ld_rdata", 32'(data_rdata), 32'hBEEF);
        chk("ld_ir_kept", 32'(ir), 32'hC0DE);
        chk("ld_ir_valid_kept", 32'(ir_valid), 32'h1);
        step();
        @(negedge clk);
        chk("ld_done_pulse", 32'(data_done), 32'h0);
        data_req = 1'b1; data_addr = 8'h81; data_we = 1'b1; data_wdata = 16'hCAFE;
        step();
        @(negedge clk);
        chk("st_mem_we", 32'(mem_we), 32'h1);
        chk("st_mem_wdata", 32'(mem_wdata), 32'hCAFE);
        chk("st_mem_addr", 32'(mem_addr), 32'h81);
        step();
        @(negedge clk);
        data_req = 1'b0; data_we = 1'b0;
        chk("st_done", 32'(data_done), 32'h1);
        chk("st_rdata_kept", 32'(data_rdata), 32'hBEEF);
        chk("st_mem_written", 32'(mem_arr[8'h81]), 32'hCAFE);
        step();

        // Redirect during a data access parked from FULL: returns to FETCH at the new target.
        lat = 2; data_req = 1'b1; data_addr = 8'h10;
        step(); redirect = 1'b1; redirect_addr = 8'h20;
        step(); redirect = 1'b0;
        @(negedge clk);
        chk("dredir_ir_valid", 32'(ir_valid), 32'h0);
        chk("dredir_pc", 32'(pc), 32'h20);
        step(); step();
        @(negedge clk);
        data_req = 1'b0; lat = 0;
        chk("dredir_done", 32'(data_done), 32'h1);
        chk("dredir_rdata", 32'(data_rdata), 32'h7777);
        chk("dredir_fetch_addr", 32'(mem_addr), 32'h20);
        step(); step(); step();
        @(negedge clk);
        chk("dredir_ir", 32'(ir), 32'h5A20);
        chk("dredir_pc_after", 32'(pc), 32'h21);

        // Reset in the middle of a data access, then a stray mem_valid.
        lat = 5; data_req = 1'b1; data_addr = 8'h90;
        step(); step();
        reset = 1'b1;
        #1;
        chk("arst_mem_req", 32'(mem_req), 32'h0);
        chk("arst_pc", 32'(pc), 32'h00);
        chk("arst_ir", 32'(ir), 32'h0000);
        chk("arst_ir_valid", 32'(ir_valid), 32'h0);
        chk("arst_data_rdata", 32'(data_rdata), 32'h0000);
        chk("arst_mem_addr", 32'(mem_addr), 32'h00);
        data_req = 1'b0;
        step(); reset = 1'b0;
        @(negedge clk);
        force_valid = 1'b1;
        step(); step();
        @(negedge clk);
        force_valid = 1'b0;
        chk("late_valid_mem_req", 32'(mem_req), 32'h0);
        chk("late_valid_done", 32'(data_done), 32'h0);
        chk("late_valid_ir", {15'h0, ir_valid, ir}, 32'h0);

        // Redirect in IDLE sets where the first fetch goes.
        lat = 0; redirect = 1'b1; redirect_addr = 8'h30;
        step(); redirect = 1'b0; start = 1'b1;
        step(); start = 1'b0;
        @(negedge clk);
        chk("idle_redir_addr", 32'(mem_addr), 32'h30);
        step();
        @(negedge clk);
        chk("idle_redir_ir", 32'(ir), 32'h5A30);
        chk("idle_redir_pc", 32'(pc), 32'h31);
        step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
